// File: rtl/reg_file.sv
// reg_file: dual-port 32 x 8 register file exposing X/Y/Z pointer pairs with in-place inc/dec.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to read buses and pointer views.
module reg_file #(
    parameter int DATA_WIDTH   = 8,
    parameter int R_ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [R_ADDR_WIDTH-1:0] rd_addr,
    inout  wire  [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_cs,
    input  logic                    rd_we,
    input  logic                    rd_oe,
    input  logic [R_ADDR_WIDTH-1:0] rr_addr,
    inout  wire  [DATA_WIDTH-1:0]   rr_data,
    input  logic                    rr_cs,
    input  logic                    rr_we,
    input  logic                    rr_oe,
    input  logic [1:0]              ptr_sel,
    input  logic [1:0]              ptr_op,
    output logic [2*DATA_WIDTH-1:0] x_ptr,
    output logic [2*DATA_WIDTH-1:0] y_ptr,
    output logic [2*DATA_WIDTH-1:0] z_ptr,
    output logic                    ptr_conflict
);

    localparam int DEPTH = 2 ** R_ADDR_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;

    localparam logic [R_ADDR_WIDTH-1:0] X_LO = R_ADDR_WIDTH'(26);
    localparam logic [R_ADDR_WIDTH-1:0] X_HI = R_ADDR_WIDTH'(27);
    localparam logic [R_ADDR_WIDTH-1:0] Y_LO = R_ADDR_WIDTH'(28);
    localparam logic [R_ADDR_WIDTH-1:0] Y_HI = R_ADDR_WIDTH'(29);
    localparam logic [R_ADDR_WIDTH-1:0] Z_LO = R_ADDR_WIDTH'(30);
    localparam logic [R_ADDR_WIDTH-1:0] Z_HI = R_ADDR_WIDTH'(31);

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_RSVD = 2'd3
    } ptr_op_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                    rd_wr, rr_wr, rd_rd, rr_rd;
    logic [R_ADDR_WIDTH-1:0] ptr_lo, ptr_hi;
    logic                    ptr_active, ptr_hit;
    logic [PW-1:0]           ptr_cur, ptr_next;

    assign rd_wr = rd_cs && rd_we;
    assign rr_wr = rr_cs && rr_we;
    assign rd_rd = rd_cs && rd_oe && !rd_we;
    assign rr_rd = rr_cs && rr_oe && !rr_we;

    // Storage view seen by readers; with bypass, in-flight writes override stored data.
    function automatic logic [DATA_WIDTH-1:0] view(input logic [R_ADDR_WIDTH-1:0] a);
`ifdef REG_FILE_BYPASS_EN
        if (rd_wr && rd_addr == a) return rd_data;
        if (rr_wr && rr_addr == a) return rr_data;
`endif
        return mem[a];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ptr_lo = X_LO;
        case (ptr_sel)
            2'd2:    ptr_lo = Y_LO;
            2'd3:    ptr_lo = Z_LO;
            default: ptr_lo = X_LO;
        endcase
        ptr_hi     = {ptr_lo[R_ADDR_WIDTH-1:1], 1'b1};
        ptr_active = (ptr_sel != 2'd0) && (ptr_op_e'(ptr_op) inside {OP_INC, OP_DEC});
        // A port write to either byte of the selected pair cancels the whole update.
        ptr_hit    = (rd_wr && rd_addr[R_ADDR_WIDTH-1:1] == ptr_lo[R_ADDR_WIDTH-1:1]) ||
                     (rr_wr && rr_addr[R_ADDR_WIDTH-1:1] == ptr_lo[R_ADDR_WIDTH-1:1]);
        ptr_cur    = {mem[ptr_hi], mem[ptr_lo]};
        ptr_next   = (ptr_op_e'(ptr_op) == OP_INC) ? ptr_cur + PW'(1) : ptr_cur - PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is plain flops, so it is cleared by reset like any other register.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr_conflict <= 1'b0;
        end else begin
            if (ptr_active && !ptr_hit) begin
                mem[ptr_lo] <= ptr_next[DATA_WIDTH-1:0];
                mem[ptr_hi] <= ptr_next[PW-1:DATA_WIDTH];
            end
            if (rr_wr) mem[rr_addr] <= rr_data;
            // NOTE: non-blocking updates; the later Rd assignment wins a same-address collision.
            if (rd_wr) mem[rd_addr] <= rd_data;
            ptr_conflict <= ptr_active && ptr_hit;
        end
    end

    assign rd_data = rd_rd ? view(rd_addr) : {DATA_WIDTH{1'bz}};
    assign rr_data = rr_rd ? view(rr_addr) : {DATA_WIDTH{1'bz}};

    assign x_ptr = {view(X_HI), view(X_LO)};
    assign y_ptr = {view(Y_HI), view(Y_LO)};
    assign z_ptr = {view(Z_HI), view(Z_LO)};

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, randomized model comparison, reset corners.
module tb_reg_file;

    logic       clk;
    logic       rst_n;
    logic [4:0] rd_addr, rr_addr;
    logic       rd_cs, rd_we, rd_oe, rr_cs, rr_we, rr_oe;
    logic [7:0] rd_val, rr_val;
    logic [1:0] ptr_sel, ptr_op;
    wire  [7:0] rd_data, rr_data;
    logic [15:0] x_ptr, y_ptr, z_ptr;
    logic        ptr_conflict;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem_m [32];
    logic       conf_m;

    assign rd_data = (rd_cs && rd_we) ? rd_val : 8'bz;
    assign rr_data = (rr_cs && rr_we) ? rr_val : 8'bz;

    reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_cs(rd_cs), .rd_we(rd_we), .rd_oe(rd_oe),
        .rr_addr(rr_addr), .rr_data(rr_data), .rr_cs(rr_cs), .rr_we(rr_we), .rr_oe(rr_oe),
        .ptr_sel(ptr_sel), .ptr_op(ptr_op),
        .x_ptr(x_ptr), .y_ptr(y_ptr), .z_ptr(z_ptr), .ptr_conflict(ptr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rdc;   // {cs, we, oe}
        logic [4:0]  rda;
        logic [7:0]  rdv;
        logic [2:0]  rrc;
        logic [4:0]  rra;
        logic [7:0]  rrv;
        logic [1:0]  sel;
        logic [1:0]  op;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_rr;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        logic [15:0] exp_z;
        logic        exp_conf;
    } vec_t;

    localparam logic [2:0] ID = 3'b000;
    localparam logic [2:0] WR = 3'b110;
    localparam logic [2:0] RD = 3'b101;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] rdc, input logic [4:0] rda, input logic [7:0] rdv,
                                input logic [2:0] rrc, input logic [4:0] rra, input logic [7:0] rrv,
                                input logic [1:0] sel, input logic [1:0] op,
                                input logic [7:0] erd, input logic [7:0] err,
                                input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                                input logic ec);
        vec_t v;
        v.rdc = rdc; v.rda = rda; v.rdv = rdv; v.rrc = rrc; v.rra = rra; v.rrv = rrv;
        v.sel = sel; v.op = op; v.exp_rd = erd; v.exp_rr = err;
        v.exp_x = ex; v.exp_y = ey; v.exp_z = ez; v.exp_conf = ec;
        return v;
    endfunction

    // Reference model: byte array plus 16-bit pointer arithmetic from the register-file rules.
    function automatic logic [7:0] mread(input logic [4:0] a);
`ifdef REG_FILE_BYPASS_EN
        if (rd_cs && rd_we && rd_addr == a) return rd_val;
        if (rr_cs && rr_we && rr_addr == a) return rr_val;
`endif
        return mem_m[a];
    endfunction

    task automatic model_edge();
        int  lo, p;
        bit  rdw, rrw, act, hit;
        rdw = rd_cs && rd_we;
        rrw = rr_cs && rr_we;
        act = (ptr_sel != 0) && (ptr_op == 1 || ptr_op == 2);
        lo  = 24 + 2 * int'(ptr_sel);
        hit = act && ((rdw && int'(rd_addr) / 2 == lo / 2) || (rrw && int'(rr_addr) / 2 == lo / 2));
        if (act && !hit) begin
            p = int'(mem_m[lo + 1]) * 256 + int'(mem_m[lo]);
            p = (ptr_op == 1) ? (p + 1) % 65536 : (p + 65535) % 65536;
            mem_m[lo]     = 8'(p % 256);
            mem_m[lo + 1] = 8'(p / 256);
        end
        if (rrw) mem_m[rr_addr] = rr_val;
        if (rdw) mem_m[rd_addr] = rd_val;
        conf_m = hit;
    endtask

    task automatic set_inputs(input vec_t v);
        {rd_cs, rd_we, rd_oe} = v.rdc; rd_addr = v.rda; rd_val = v.rdv;
        {rr_cs, rr_we, rr_oe} = v.rrc; rr_addr = v.rra; rr_val = v.rrv;
        ptr_sel = v.sel; ptr_op = v.op;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        {rd_cs, rd_we, rd_oe} = ID; rd_addr = '0; rd_val = '0;
        {rr_cs, rr_we, rr_oe} = ID; rr_addr = '0; rr_val = '0;
        ptr_sel = '0; ptr_op = '0;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 2) == 0) return 5'(26 + $urandom_range(0, 5));
        return 5'($urandom_range(0, 31));
    endfunction

    vec_t tv[$];

    initial begin
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        conf_m = 1'b0;
        idle();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("reset x_ptr", x_ptr, 0);
        check("reset y_ptr", y_ptr, 0);
        check("reset z_ptr", z_ptr, 0);
        check("reset ptr_conflict", ptr_conflict, 0);
        rd_cs = 1; rd_oe = 1; rd_addr = 5;
        rr_cs = 1; rr_oe = 1; rr_addr = 31;
        #2;
        check("reset read R5", rd_data, 8'h00);
        check("reset read R31", rr_data, 8'h00);
        idle();
        @(posedge clk); #1;

        tv.push_back(mk(WR, 16, 8'hA5, ID, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(RD, 5, 0, RD, 16, 0, 0, 0, 8'h00, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(WR, 0, 8'h34, WR, 1, 8'h12, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(RD, 0, 0, RD, 1, 0, 0, 0, 8'h34, 8'h12, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(WR, 3, 8'h11, WR, 3, 8'h22, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(RD, 3, 0, ID, 0, 0, 0, 0, 8'h11, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(WR, 26, 8'hFF, WR, 27, 8'hFF, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(ID, 0, 0, ID, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));
        tv.push_back(mk(WR, 30, 8'h00, WR, 31, 8'h01, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 0));
        tv.push_back(mk(ID, 0, 0, ID, 0, 0, 3, 2, 0, 0, 16'h0000, 16'h0000, 16'h00FF, 0));
        tv.push_back(mk(WR, 28, 8'h34, WR, 29, 8'h12, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h00FF, 0));
        tv.push_back(mk(WR, 28, 8'h55, ID, 0, 0, 2, 2, 0, 0, 16'h0000, 16'h1255, 16'h00FF, 1));
        tv.push_back(mk(ID, 0, 0, ID, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h1255, 16'h00FF, 0));
        tv.push_back(mk(ID, 0, 0, ID, 0, 0, 2, 3, 0, 0, 16'h0000, 16'h1255, 16'h00FF, 0));
`ifdef REG_FILE_BYPASS_EN
        tv.push_back(mk(WR, 7, 8'h5A, RD, 7, 0, 0, 0, 0, 8'h5A, 16'h0000, 16'h1255, 16'h00FF, 0));
`else
        tv.push_back(mk(WR, 7, 8'h5A, RD, 7, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h1255, 16'h00FF, 0));
`endif
        tv.push_back(mk(RD, 7, 0, ID, 0, 0, 0, 0, 8'h5A, 0, 16'h0000, 16'h1255, 16'h00FF, 0));
        tv.push_back(mk(WR, 26, 8'hFF, ID, 0, 0, 0, 0, 0, 0, 16'h00FF, 16'h1255, 16'h00FF, 0));
        tv.push_back(mk(ID, 0, 0, ID, 0, 0, 1, 1, 0, 0, 16'h0100, 16'h1255, 16'h00FF, 0));
        tv.push_back(mk(ID, 0, 0, ID, 0, 0, 0, 1, 0, 0, 16'h0100, 16'h1255, 16'h00FF, 0));

        foreach (tv[i]) begin
            set_inputs(tv[i]);
            #3;
            if (tv[i].rdc == RD) check($sformatf("vec%0d rd_data", i), rd_data, tv[i].exp_rd);
            if (tv[i].rrc == RD) check($sformatf("vec%0d rr_data", i), rr_data, tv[i].exp_rr);
            clock_edge();
            check($sformatf("vec%0d x_ptr", i), x_ptr, tv[i].exp_x);
            check($sformatf("vec%0d y_ptr", i), y_ptr, tv[i].exp_y);
            check($sformatf("vec%0d z_ptr", i), z_ptr, tv[i].exp_z);
            check($sformatf("vec%0d ptr_conflict", i), ptr_conflict, tv[i].exp_conf);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rd_cs = 1'($urandom_range(0, 1)); rd_we = ($urandom_range(0, 2) == 0);
            rd_oe = 1'($urandom_range(0, 1)); rd_addr = rand_addr(); rd_val = 8'($urandom);
            rr_cs = 1'($urandom_range(0, 1)); rr_we = ($urandom_range(0, 2) == 0);
            rr_oe = 1'($urandom_range(0, 1)); rr_addr = rand_addr(); rr_val = 8'($urandom);
            ptr_sel = 2'($urandom_range(0, 3)); ptr_op = 2'($urandom_range(0, 3));
            #3;
            if (rd_cs && rd_oe && !rd_we) check($sformatf("rnd%0d rd_data", c), rd_data, mread(rd_addr));
            if (rr_cs && rr_oe && !rr_we) check($sformatf("rnd%0d rr_data", c), rr_data, mread(rr_addr));
            clock_edge();
            check($sformatf("rnd%0d x_ptr", c), x_ptr, {mem_m[27], mem_m[26]});
            check($sformatf("rnd%0d y_ptr", c), y_ptr, {mem_m[29], mem_m[28]});
            check($sformatf("rnd%0d z_ptr", c), z_ptr, {mem_m[31], mem_m[30]});
            check($sformatf("rnd%0d ptr_conflict", c), ptr_conflict, conf_m);
        end

        // Reset asserted during a write to R9: write lost, state clears asynchronously
        idle();
        rd_cs = 1; rd_we = 1; rd_addr = 26; rd_val = 8'hAA;
        clock_edge();
        check("pre-reset x_ptr low byte", x_ptr[7:0], 8'hAA);
        rd_addr = 9; rd_val = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        check("async reset x_ptr", x_ptr, 0);
        check("async reset y_ptr", y_ptr, 0);
        check("async reset z_ptr", z_ptr, 0);
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        rr_cs = 1; rr_oe = 1; rr_addr = 9;
        #2;
        check("R9 after mid-write reset", rr_data, 8'h00);
        idle();
        rd_cs = 1; rd_we = 1; rd_addr = 9; rd_val = 8'h3C;
        clock_edge();
        idle();
        rr_cs = 1; rr_oe = 1; rr_addr = 9;
        #2;
        check("first write after reset R9", rr_data, 8'h3C);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
